// File: rtl/contador_modn_cascata.sv
// Multi-digit modulo-RADIX up/down counter with load, wrap/saturate and cascade terminal count.
// Latency: count/wrapped update one clk after load/enable is sampled; tc is combinational.
// Backpressure: none; every non-reset, non-load edge with enable high advances or saturates.
module contador_modn_cascata #(
  parameter int RADIX  = 10,
  parameter int DIGITS = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                up_down,
  input  logic                                load,
  input  logic [DIGITS*$clog2(RADIX)-1:0]     load_value,
  input  logic                                saturate,
  output logic [DIGITS*$clog2(RADIX)-1:0]     count,
  output logic                                tc,
  output logic                                wrapped
);

  localparam int W = $clog2(RADIX);
  localparam logic [W-1:0] DMAX = W'(RADIX - 1);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W:0]   RADX = (W+1)'(RADIX);

  logic [DIGITS*W-1:0] count_q;
  logic                wrapped_q;
  logic [DIGITS*W-1:0] step_count;
  logic [DIGITS*W-1:0] load_clamped;
  logic                at_max;
  logic                at_zero;
  logic                at_limit;
  logic                carry;
  logic [W-1:0]        dig;

  // Detect whether every digit sits at the top or bottom of its range.
  always_comb begin
    at_max  = 1'b1;
    at_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[i*W +: W] != DMAX) at_max  = 1'b0;
      if (count_q[i*W +: W] != '0)   at_zero = 1'b0;
    end
  end

  assign at_limit = up_down ? at_max : at_zero;
  assign tc       = enable & at_limit;

  // Ripple carry/borrow across digits; a digit only moves when all lower digits rolled over.
  always_comb begin
    step_count = count_q;
    carry      = 1'b1;
    dig        = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[i*W +: W];
      if (carry) begin
        if (up_down) begin
          if (dig == DMAX) begin
            step_count[i*W +: W] = '0;
          end else begin
            step_count[i*W +: W] = dig + ONE;
            carry                = 1'b0;
          end
        end else begin
          if (dig == '0) begin
            step_count[i*W +: W] = DMAX;
          end else begin
            step_count[i*W +: W] = dig - ONE;
            carry                = 1'b0;
          end
        end
      end
    end
  end

  // Clamp each loaded digit into 0..RADIX-1 so an illegal digit can never reach count.
  always_comb begin
    load_clamped = load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, load_value[i*W +: W]} >= RADX) load_clamped[i*W +: W] = DMAX;
    end
  end

  // State update with priority reset > load > enable > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else if (load) begin
      count_q   <= load_clamped;
      wrapped_q <= 1'b0;
    end else if (enable) begin
      if (!(at_limit && saturate)) begin
        count_q <= step_count;
        if (at_limit) wrapped_q <= 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_contador_modn_cascata.sv
module tb_contador_modn_cascata;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RADIX=10, DIGITS=2 (4-bit digits)
  logic       a_reset, a_enable, a_up_down, a_load, a_saturate;
  logic [7:0] a_load_value, a_count;
  logic       a_tc, a_wrapped;

  // Instance B: RADIX=6, DIGITS=3 (3-bit digits)
  logic       b_reset, b_enable, b_up_down, b_load, b_saturate;
  logic [8:0] b_load_value, b_count;
  logic       b_tc, b_wrapped;

  contador_modn_cascata #(.RADIX(10), .DIGITS(2)) dut_a (
    .clk(clk), .reset(a_reset), .enable(a_enable), .up_down(a_up_down),
    .load(a_load), .load_value(a_load_value), .saturate(a_saturate),
    .count(a_count), .tc(a_tc), .wrapped(a_wrapped)
  );

  contador_modn_cascata #(.RADIX(6), .DIGITS(3)) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .up_down(b_up_down),
    .load(b_load), .load_value(b_load_value), .saturate(b_saturate),
    .count(b_count), .tc(b_tc), .wrapped(b_wrapped)
  );

  typedef struct {
    bit          dut_b;
    logic [11:0] cnt;
    logic        tcx;
    logic        wr;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] d3(input int h, input int t, input int u);
    return {3'b000, h[2:0], t[2:0], u[2:0]};
  endfunction

  // Drive one cycle of inputs on the selected instance and queue the post-edge expectation.
  task automatic drv(input bit b, input logic rst, input logic ld, input logic en,
                     input logic ud, input logic sat, input logic [11:0] lv,
                     input logic [11:0] ec, input logic et, input logic ew, input string nm);
    @(negedge clk);
    a_reset = 1'b0; a_load = 1'b0; a_enable = 1'b0;
    b_reset = 1'b0; b_load = 1'b0; b_enable = 1'b0;
    if (!b) begin
      a_reset = rst; a_load = ld; a_enable = en; a_up_down = ud; a_saturate = sat;
      a_load_value = lv[7:0];
    end else begin
      b_reset = rst; b_load = ld; b_enable = en; b_up_down = ud; b_saturate = sat;
      b_load_value = lv[8:0];
    end
    sb.push_back('{b, ec, et, ew, nm});
  endtask

  // Monitor: after each rising edge, pop one expectation and compare against the DUT.
  initial begin : monitor
    exp_t e;
    int   maxd;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!e.dut_b) begin
          check({e.name, ".count"},   {4'h0, a_count},    e.cnt);
          check({e.name, ".tc"},      {11'h0, a_tc},      {11'h0, e.tcx});
          check({e.name, ".wrapped"}, {11'h0, a_wrapped}, {11'h0, e.wr});
        end else begin
          check({e.name, ".count"},   {3'h0, b_count},    e.cnt);
          check({e.name, ".tc"},      {11'h0, b_tc},      {11'h0, e.tcx});
          check({e.name, ".wrapped"}, {11'h0, b_wrapped}, {11'h0, e.wr});
          maxd = 0;
          for (int i = 0; i < 3; i++)
            if (int'(b_count[i*3 +: 3]) > maxd) maxd = int'(b_count[i*3 +: 3]);
          n_cmp++;
          if (maxd > 5) begin
            n_err++;
            $display("FAIL %s.digit_range: got max digit %0d expected at most 5", e.name, maxd);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    a_reset = 1'b1; a_load = 1'b0; a_enable = 1'b0; a_up_down = 1'b1; a_saturate = 1'b0;
    a_load_value = 8'h00;
    b_reset = 1'b1; b_load = 1'b0; b_enable = 1'b0; b_up_down = 1'b1; b_saturate = 1'b0;
    b_load_value = 9'h000;

    // Reset state
    drv(0, 1, 0, 0, 1, 0, 12'h000, 12'h000, 0, 0, "reset");

    // 100 up steps: 01..99 then wrap to 00
    for (int k = 1; k <= 100; k++) begin
      int m;
      m = k % 100;
      drv(0, 0, 0, 1, 1, 0, 12'h000, 12'((m / 10) * 16 + (m % 10)), (m == 99), (k == 100), "up100");
    end

    // Load beats enable, then down steps including a digit borrow
    drv(0, 0, 1, 1, 1, 0, 12'h057, 12'h057, 0, 0, "load57");
    drv(0, 0, 0, 1, 0, 0, 12'h000, 12'h056, 0, 0, "down56");
    drv(0, 0, 1, 0, 0, 0, 12'h050, 12'h050, 0, 0, "load50");
    drv(0, 0, 0, 1, 0, 0, 12'h000, 12'h049, 0, 0, "borrow49");

    // Illegal load digits are clamped to 9
    drv(0, 0, 1, 0, 1, 0, 12'h0FA, 12'h099, 0, 0, "loadFA");
    drv(0, 0, 1, 0, 1, 0, 12'h03F, 12'h039, 0, 0, "load3F");

    // Saturate up at 99
    drv(0, 0, 1, 0, 1, 1, 12'h098, 12'h098, 0, 0, "load98");
    for (int k = 0; k < 3; k++)
      drv(0, 0, 0, 1, 1, 1, 12'h000, 12'h099, 1, 0, "sat_up");
    drv(0, 0, 0, 0, 0, 1, 12'h000, 12'h099, 0, 0, "dir_only_hold");

    // Saturate down at 00
    drv(0, 0, 1, 0, 0, 1, 12'h001, 12'h001, 0, 0, "load01");
    for (int k = 0; k < 3; k++)
      drv(0, 0, 0, 1, 0, 1, 12'h000, 12'h000, 1, 0, "sat_down");

    // Down wrap 00 -> 99 sets wrapped; load clears it
    drv(0, 0, 0, 1, 0, 0, 12'h000, 12'h099, 0, 1, "down_wrap");
    drv(0, 0, 0, 0, 1, 1, 12'h000, 12'h099, 0, 1, "hold_en0");
    drv(0, 0, 1, 0, 1, 0, 12'h000, 12'h000, 0, 0, "load00");

    // Reset overrides load and enable mid-count
    drv(0, 0, 1, 0, 1, 0, 12'h073, 12'h073, 0, 0, "load73");
    drv(0, 1, 1, 1, 1, 0, 12'h073, 12'h000, 0, 0, "rst_over_load");
    drv(0, 0, 0, 1, 1, 0, 12'h000, 12'h001, 0, 0, "resume");

    // Reset clears a set wrapped flag
    drv(0, 0, 1, 0, 1, 0, 12'h099, 12'h099, 0, 0, "load99");
    drv(0, 0, 0, 1, 1, 0, 12'h000, 12'h000, 0, 1, "up_wrap");
    drv(0, 1, 0, 0, 1, 0, 12'h000, 12'h000, 0, 0, "rst_clr_wrap");

    // Instance B: RADIX=6, DIGITS=3
    drv(1, 0, 1, 0, 1, 0, d3(5, 5, 4), d3(5, 5, 4), 0, 0, "b_load554");
    drv(1, 0, 0, 1, 1, 0, 12'h000, d3(5, 5, 5), 1, 0, "b_555");
    drv(1, 0, 0, 1, 1, 0, 12'h000, d3(0, 0, 0), 0, 1, "b_wrap000");
    drv(1, 0, 0, 1, 1, 0, 12'h000, d3(0, 0, 1), 0, 1, "b_001");
    drv(1, 0, 1, 0, 1, 0, d3(7, 6, 2), d3(5, 5, 2), 0, 0, "b_clamp");
    drv(1, 0, 0, 1, 1, 0, 12'h000, d3(5, 5, 3), 0, 0, "b_553");
    drv(1, 0, 1, 0, 0, 0, d3(1, 0, 0), d3(1, 0, 0), 0, 0, "b_load100");
    drv(1, 0, 0, 1, 0, 0, 12'h000, d3(0, 5, 5), 0, 0, "b_borrow055");
    drv(1, 0, 1, 0, 0, 0, d3(0, 0, 0), d3(0, 0, 0), 0, 0, "b_load000");
    drv(1, 0, 0, 1, 0, 0, 12'h000, d3(5, 5, 5), 0, 1, "b_down_wrap");

    // Drain the scoreboard with a bounded wait
    @(negedge clk);
    b_enable = 1'b0; b_load = 1'b0;
    for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/contador_modn_cascata.md
# contador_modn_cascata

Parametrised multi-digit modulo-N counter. It is the successor to the single-digit mod-10 counter. It chains DIGITS digits of radix RADIX, each digit counting 0..RADIX-1 (default: two BCD digits, 00..99). It adds the following:
- up/down direction
- synchronous parallel load
- wrap or saturate mode at the range limits
- a combinational terminal-count output, for cascading further instances
- a sticky wrap flag

It serves as the timebase/event counter for the display and timer paths.

## Interface
- RADIX, 10, modulus of each digit; legal range 2..16
- DIGITS, 2, number of cascaded digits; legal range 1..8
- W (localparam), $clog2(RADIX), bits per digit (4 for RADIX=10)
- clk  input  1  rising-edge clock; one clock domain; reset is synchronous and active-high
- reset  input  1  synchronous, active-high; clears all state on the next clk edge
- enable  input  1  count one step on this edge when high
- up_down  input  1  1 = count up, 0 = count down
- load  input  1  capture load_value on this edge
- load_value  input  DIGITS*W  parallel load value; digit 0 in bits [W-1:0]
- saturate  input  1  1 = hold at the range limit, 0 = wrap around
- count  output  DIGITS*W  registered count; digit 0 is least significant, in bits [W-1:0]
- tc  output  1  combinational terminal count, for cascading
- wrapped  output  1  registered sticky flag: at least one wrap has occurred

## Operation
- Register update priority on each rising clk edge: reset > load > enable > hold.
- reset: count = 0, wrapped = 0. tc is then 0 unless enable=1 and up_down=0.
- load:
  - each digit of load_value whose value is RADIX or above is clamped to RADIX-1 before capture;
  - wrapped is cleared;
  - enable is ignored on a load cycle.
- enable, count up:
  - digit 0 increments;
  - a digit at RADIX-1 rolls to 0 and carries into the next digit;
  - digit i changes only if every lower digit is at RADIX-1.
- enable, count down:
  - digit 0 decrements;
  - a digit at 0 rolls to RADIX-1 and borrows from the next digit.
- Range limit: all digits at RADIX-1 when counting up; all digits at 0 when counting down.
  - saturate=0: count wraps to the opposite end (99→00 up, 00→99 down) and wrapped is set to 1.
  - saturate=1: count holds at the limit and wrapped is unchanged.
- tc = enable & (count at the range limit for the current up_down). tc is asserted regardless of saturate.
  - Feed tc into the enable input of the next instance to extend the count.
- enable=0: count and wrapped hold. A change of up_down or saturate alone never alters count.
- Per-digit arithmetic is W bits wide. No intermediate value may exceed RADIX-1, and no digit value of RADIX or above may ever appear on count.

## Timing
- count and wrapped change only on a rising clk edge. Both are 0 from the first edge on which reset is sampled high.
- Latency: one cycle from an enable/load sample to the new count.
- tc is purely combinational from count, enable and up_down, so it is valid in the same cycle. It must not be registered.
- Reset asserted mid-count overrides load and enable on that edge. Counting resumes from 0 on the first edge with reset low.
- load and enable high together: load wins, and the loaded value appears unmodified next cycle.
- up_down may change every cycle; each edge uses the value sampled on that edge.
- No handshake. Every edge with enable=1 that is not a reset or load edge advances the count exactly one step, or holds under saturate.

## Test plan
All scenarios use defaults RADIX=10, DIGITS=2 unless stated.
- Reset, then enable=1, up_down=1, saturate=0 for 100 cycles -> count steps 00,01..09,10..99,00; tc=1 only while count=99; wrapped=1 after the 99→00 edge.
- Load 8'h57 with enable=1 on the same edge -> count=57 next cycle; next edge with enable=1, up_down=0 -> 56; with count=50, one down step -> 49.
- Load 8'hFA (both digits illegal) -> count=99; wrapped=0.
- Saturate=1: from 98, enable up for 3 cycles -> 99, 99, 99 and tc=1 throughout; from 01, enable down for 3 cycles -> 00, 00, 00; wrapped stays 0.
- Down wrap, saturate=0: count=00, enable=1, up_down=0 -> tc=1 the same cycle; next count=99; wrapped=1. Then load 8'h00 -> wrapped=0.
- Reset mid-operation: count=73 with load=1 and reset=1 on the same edge -> count=00, wrapped=0. Also run RADIX=6, DIGITS=3: up-counting from 555 wraps to 000, and no digit value above 5 ever appears.
